// File: rtl/mcb_ref_arb.sv
// Refresh scheduler and command-bus arbiter for the sdrc_lite MCB back-end.
// Tracks postponed refreshes and sequences PREA / tRP / REF / tRFC.
module mcb_ref_arb #(
  parameter int REF_INT   = 1560,
  parameter int REF_CNT_W = 11,
  parameter int PEND_W    = 3,
  parameter int MAX_PEND  = 7,
  parameter int URG_TH    = 4,
  parameter int CtRPm1    = 2,
  parameter int CtRFCm1   = 7
) (
  input  logic              mcb_clk,
  input  logic              mcb_rst_n,
  input  logic              mcb_sclr_n,
  input  logic              i_ready,
  input  logic              acc_req,
  input  logic              acc_idle,
  output logic              acc_gnt,
  output logic              ref_prea,
  output logic              ref_cmd,
  output logic              ref_busy,
  output logic              ref_urgent,
  output logic [PEND_W-1:0] ref_pend,
  output logic              ref_ovf
);

  localparam int CMD_MAX = (CtRPm1 > CtRFCm1) ? CtRPm1 : CtRFCm1;
  localparam int CMD_W   = (CMD_MAX < 2) ? 1 : $clog2(CMD_MAX + 1);

  localparam logic [CMD_W-1:0] RP_LAST =
    CMD_W'((CtRPm1 > 0) ? CtRPm1 - 1 : 0);
  localparam logic [CMD_W-1:0] RFC_LAST =
    CMD_W'((CtRFCm1 > 0) ? CtRFCm1 - 1 : 0);
  localparam logic [REF_CNT_W-1:0] IVL_LAST = REF_CNT_W'(REF_INT - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_PREA,
    S_TRP,
    S_REF,
    S_TRFC
  } state_t;

  state_t               state_q, state_d;
  logic [REF_CNT_W-1:0] ivl_q, ivl_d;
  logic [PEND_W-1:0]    pend_q, pend_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic                 ovf_q, ovf_d;

  logic tick, issue;
  logic urgent, urgent_d;
  logic want_q, want_d;

  always_comb begin
    tick  = i_ready && (ivl_q == IVL_LAST);
    ivl_d = '0;
    if (i_ready && !tick) ivl_d = ivl_q + 1'b1;

    issue  = (state_q == S_REF);
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (tick && !issue) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (issue && !tick) begin
      pend_d = pend_q - 1'b1;
    end

    urgent   = (int'(pend_q) >= URG_TH);
    urgent_d = (int'(pend_d) >= URG_TH);
    // Refresh wins when it is urgent or the access side is quiet.
    want_q = (pend_q != '0) && (urgent || !acc_req);
    want_d = (pend_d != '0) && (urgent_d || !acc_req);
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    acc_gnt  = 1'b0;
    ref_prea = 1'b0;
    ref_cmd  = 1'b0;
    ref_busy = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_ready) begin
          if (want_q)       state_d = acc_idle ? S_REF : S_PREA;
          else if (acc_req) state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_gnt = acc_req && !urgent;
        if (!acc_req) state_d = S_IDLE;
      end
      S_PREA: begin
        ref_prea = 1'b1;
        ref_busy = 1'b1;
        cmd_d    = '0;
        state_d  = (CtRPm1 == 0) ? S_REF : S_TRP;
      end
      S_TRP: begin
        ref_busy = 1'b1;
        cmd_d    = cmd_q + 1'b1;
        if (cmd_q == RP_LAST) state_d = S_REF;
      end
      S_REF: begin
        ref_cmd  = 1'b1;
        ref_busy = 1'b1;
        cmd_d    = '0;
        if (CtRFCm1 != 0) state_d = S_TRFC;
        else              state_d = want_d ? S_REF : S_IDLE;
      end
      S_TRFC: begin
        ref_busy = 1'b1;
        cmd_d    = cmd_q + 1'b1;
        // Chained refreshes skip PREA: rows are already closed.
        if (cmd_q == RFC_LAST) state_d = want_q ? S_REF : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      state_q <= S_IDLE;
      ivl_q   <= '0;
      pend_q  <= '0;
      cmd_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (!mcb_sclr_n) begin
      state_q <= S_IDLE;
      ivl_q   <= '0;
      pend_q  <= '0;
      cmd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ref_urgent = urgent;
  assign ref_pend   = pend_q;
  assign ref_ovf    = ovf_q;

endmodule
